clint_tick_master: RTL

- Bus initiator that drives the CLINT timer registers so the core does not have to.
- On arm, or on each mtip assertion for its hart, it reads mtime and adds a programmable period.
- It then rewrites that hart's mtimecmp using the glitch-free sequence: high word all-ones, then low word, then high word.
- Sits on the peripheral bus beside the core master and gives a periodic hardware tick with no software in the loop.

---
 rtl/clint_pkg.sv | 29 ++
 rtl/clint_bus_xfer.sv | 53 +++++
 rtl/clint_tick_master.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// CLINT address map, tick-master state encoding and bus strobe constants
// shared by the CLINT tick master and its bus transfer engine.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_BASE    = 16'hbff8;
  localparam int unsigned CLINT_HART_STRIDE   = 8;

  localparam logic [3:0] WSTRB_WR = 4'hF;
  localparam logic [3:0] WSTRB_RD = 4'h0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_HI1,
    S_RD_LO,
    S_RD_HI2,
    S_WR_HMAX,
    S_WR_LO,
    S_WR_HI,
    S_DONE,
    S_HOLD
  } clint_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/clint_bus_xfer.sv
// Single-transfer bus engine: launches one request on start, holds it until
// m_ready, then pulses done with the captured read data.
module clint_bus_xfer
  import clint_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  we,
  output logic                  done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready
);

  // m_valid drops on completion, so a start can only launch after a gap cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid   <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          m_valid <= 1'b0;
          done    <= 1'b1;
        end
      end else if (start) begin
        m_valid   <= 1'b1;
        m_address <= addr;
        m_wdata   <= wdata;
        m_wstrb   <= we ? (DATA_W/8)'(WSTRB_WR) : (DATA_W/8)'(WSTRB_RD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (m_valid && m_ready) rdata <= m_rdata;
  end

endmodule

// File: rtl/clint_tick_master.sv
// Periodic CLINT tick generator: samples mtime (hi-lo-hi), adds a period and
// rewrites this hart's mtimecmp without ever exposing a transient early match.
module clint_tick_master
  import clint_pkg::*;
#(
  parameter int          ADDR_W        = 32,
  parameter int          DATA_W        = 32,
  parameter int          HART          = 0,
  parameter logic [15:0] MTIME_BASE    = CLINT_MTIME_BASE,
  parameter logic [15:0] MTIMECMP_BASE = CLINT_MTIMECMP_BASE,
  parameter int          HOLDOFF       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [63:0]         period,
  input  logic                mtip,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                tick,
  output logic                busy,
  output logic [7:0]          retries
);

  localparam logic [ADDR_W-1:0] MTIME_LO_A = ADDR_W'(MTIME_BASE);
  localparam logic [ADDR_W-1:0] MTIME_HI_A = MTIME_LO_A + ADDR_W'(4);
  localparam logic [ADDR_W-1:0] CMP_LO_A   = ADDR_W'(MTIMECMP_BASE) + ADDR_W'(CLINT_HART_STRIDE * HART);
  localparam logic [ADDR_W-1:0] CMP_HI_A   = CMP_LO_A + ADDR_W'(4);
  localparam logic [7:0]        HOLD_LAST  = 8'(HOLDOFF - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } req_t;

  clint_state_t      state;
  logic              armed;
  logic [63:0]       period_q;
  logic [63:0]       target;
  logic [31:0]       hi1;
  logic [31:0]       lo;
  logic [7:0]        hold_cnt;
  logic              start;
  req_t              req_q;
  logic              x_done;
  logic [DATA_W-1:0] x_rdata;

  // Bus request launched on entry to each transfer state.
  function automatic req_t bus_req(input clint_state_t s, input logic [63:0] tgt);
    req_t r;
    r.addr  = MTIME_LO_A;
    r.wdata = '0;
    r.we    = 1'b0;
    case (s)
      S_RD_HI1, S_RD_HI2: r.addr = MTIME_HI_A;
      S_WR_HMAX: begin
        r.addr  = CMP_HI_A;
        r.wdata = '1;
        r.we    = 1'b1;
      end
      S_WR_LO: begin
        r.addr  = CMP_LO_A;
        r.wdata = tgt[31:0];
        r.we    = 1'b1;
      end
      S_WR_HI: begin
        r.addr  = CMP_HI_A;
        r.wdata = tgt[63:32];
        r.we    = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      tick     <= 1'b0;
      retries  <= 8'd0;
      start    <= 1'b0;
      hold_cnt <= 8'd0;
    end else begin
      start <= 1'b0;
      tick  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!enable) begin
            armed <= 1'b0;
          end else if (!armed || mtip) begin
            armed    <= 1'b1;
            period_q <= period;
            state    <= S_RD_HI1;
            start    <= 1'b1;
            req_q    <= bus_req(S_RD_HI1, target);
          end
        end
        S_RD_HI1: if (x_done) begin
          hi1   <= x_rdata;
          state <= S_RD_LO;
          start <= 1'b1;
          req_q <= bus_req(S_RD_LO, target);
        end
        S_RD_LO: if (x_done) begin
          lo    <= x_rdata;
          state <= S_RD_HI2;
          start <= 1'b1;
          req_q <= bus_req(S_RD_HI2, target);
        end
        S_RD_HI2: if (x_done) begin
          // A changed high word means the low word carried between reads.
          if (x_rdata != hi1) begin
            hi1     <= x_rdata;
            retries <= sat_inc8(retries);
            state   <= S_RD_LO;
            start   <= 1'b1;
            req_q   <= bus_req(S_RD_LO, target);
          end else begin
            target <= {hi1, lo} + period_q;
            state  <= S_WR_HMAX;
            start  <= 1'b1;
            req_q  <= bus_req(S_WR_HMAX, target);
          end
        end
        S_WR_HMAX: if (x_done) begin
          state <= S_WR_LO;
          start <= 1'b1;
          req_q <= bus_req(S_WR_LO, target);
        end
        S_WR_LO: if (x_done) begin
          state <= S_WR_HI;
          start <= 1'b1;
          req_q <= bus_req(S_WR_HI, target);
        end
        S_WR_HI: if (x_done) begin
          state <= S_DONE;
          tick  <= 1'b1;
        end
        S_DONE: begin
          hold_cnt <= 8'd0;
          state    <= (HOLDOFF == 0) ? S_IDLE : S_HOLD;
        end
        S_HOLD: begin
          // The responder's mtip lags the final write; ignore it meanwhile.
          if (hold_cnt == HOLD_LAST) state <= S_IDLE;
          else hold_cnt <= hold_cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  clint_bus_xfer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_xfer (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr      (req_q.addr),
    .wdata     (req_q.wdata),
    .we        (req_q.we),
    .done      (x_done),
    .rdata     (x_rdata),
    .m_valid   (m_valid),
    .m_address (m_address),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

endmodule
